// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment driver: sequential double-dabble BCD conversion,
// leading-zero blanking, per-digit decimal points and whole-display blink.
module fnd_scan_driver #(
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_TICKS    = 250
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        tick_1khz,
    input  logic [13:0] value,
    input  logic        blink,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  fnd_sel,
    output logic [7:0]  fnd_seg,
    output logic        conv_busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Nibble code never produced by BCD; marks a dash digit in the display register.
    localparam logic [3:0] DASH_CODE  = 4'hF;
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_TICKS - 1);
    localparam logic [3:0] SEL_OFF    = SEL_ACTIVE_LOW ? 4'b1111 : 4'b0000;
    localparam logic [7:0] SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_e      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [15:0] disp_q, disp_d;
    logic [1:0]  idx_q, idx_d;
    logic [9:0]  blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  fnd_sel_q, fnd_sel_d;
    logic [7:0]  fnd_seg_q, fnd_seg_d;
    logic        conv_busy_q, conv_busy_d;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:      s = 7'h3F;
            4'd1:      s = 7'h06;
            4'd2:      s = 7'h5B;
            4'd3:      s = 7'h4F;
            4'd4:      s = 7'h66;
            4'd5:      s = 7'h6D;
            4'd6:      s = 7'h7D;
            4'd7:      s = 7'h07;
            4'd8:      s = 7'h7F;
            4'd9:      s = 7'h6F;
            DASH_CODE: s = 7'h40;
            default:   s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= 14'd0;
            bcd_q       <= 16'd0;
            cnt_q       <= 4'd0;
            ovf_q       <= 1'b0;
            disp_q      <= 16'd0;
            idx_q       <= 2'd0;
            blink_cnt_q <= 10'd0;
            phase_q     <= 1'b0;
            fnd_sel_q   <= SEL_OFF;
            fnd_seg_q   <= SEG_OFF;
            conv_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            disp_q      <= disp_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            fnd_sel_q   <= fnd_sel_d;
            fnd_seg_q   <= fnd_seg_d;
            conv_busy_q <= conv_busy_d;
        end
    end

    // Conversion FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tick_1khz) state_d = ST_SHIFT; else state_d = ST_IDLE;
            ST_SHIFT: if (cnt_q == 4'd0) state_d = ST_LATCH; else state_d = ST_SHIFT;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Conversion datapath and busy flag.
    always_comb begin
        logic [29:0] shifted;
        shifted = 30'd0;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_1khz) begin
                    bin_d = value;
                    bcd_d = 16'd0;
                    cnt_d = 4'd13;
                    ovf_d = (value > 14'd9999);
                end else begin
                    bin_d = bin_q;
                end
            end
            ST_SHIFT: begin
                shifted = {dabble(bcd_q), bin_q} << 1;
                bcd_d   = shifted[29:14];
                bin_d   = shifted[13:0];
                cnt_d   = cnt_q - 4'd1;
            end
            ST_LATCH: begin
                if (ovf_q) disp_d = {4{DASH_CODE}};
                else       disp_d = bcd_q;
            end
            default: disp_d = disp_q;
        endcase
        conv_busy_d = (state_d != ST_IDLE);
    end

    // Scan index, blink phase and registered pin drive.
    always_comb begin
        logic [7:0] seg_lit;
        logic       lead_zero;
        idx_d       = idx_q;
        fnd_sel_d   = fnd_sel_q;
        fnd_seg_d   = fnd_seg_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        case (idx_q)
            2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
            2'd2:    lead_zero = (disp_q[15:8] == 8'd0);
            2'd1:    lead_zero = (disp_q[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
        if (lead_zero) seg_lit = 8'h00;
        else           seg_lit = {1'b0, seg7(disp_q[4*idx_q +: 4])};
        seg_lit[7] = dp_mask[idx_q];
        if (phase_q) seg_lit = 8'h00;
        else         seg_lit = seg_lit;

        if (tick_1khz) begin
            idx_d     = idx_q + 2'd1;
            fnd_sel_d = SEL_ACTIVE_LOW ? ~(4'b0001 << idx_q) : (4'b0001 << idx_q);
            fnd_seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        end else begin
            idx_d = idx_q;
        end

        if (!blink) begin
            blink_cnt_d = 10'd0;
            phase_d     = 1'b0;
        end else if (tick_1khz) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 10'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 10'd1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    assign fnd_sel   = fnd_sel_q;
    assign fnd_seg   = fnd_seg_q;
    assign conv_busy = conv_busy_q;
endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Drives the 4-digit multiplexed FND (7-segment) display from a 14-bit binary value. The value is converted to BCD by a sequential double-dabble FSM, leading zeros are blanked, and one digit is scanned per 1 kHz tick. It also supports per-digit decimal points and a blink mode. It sits between the speed/RPM control path and the board `fnd_sel`/`fnd_seg` pins, and consumes the same `clk_1khz` tick domain as the button auto-repeat logic.

## Interface
- `SEL_ACTIVE_LOW`, 1: when 1, `fnd_sel` is inverted (active digit = 0).
- `SEG_ACTIVE_LOW`, 1: when 1, `fnd_seg` is inverted (lit segment = 0).
- `BLINK_TICKS`, 250: number of ticks per blink half-period. Legal range is 2..1023.

- `clk_100mhz` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1khz` in 1: one-cycle enable pulse at 1 kHz.
- `value` in 14: binary value to display, 0..9999. Values ≥10000 are an overflow.
- `blink` in 1: 1 = blink the whole display.
- `dp_mask` in 4: decimal point enable per digit. Bit i = digit i; digit 0 is the rightmost.
- `fnd_sel` out 4: digit select, one-hot, with polarity set by `SEL_ACTIVE_LOW`.
- `fnd_seg` out 8: segments {dp,g,f,e,d,c,b,a}, with polarity set by `SEG_ACTIVE_LOW`.
- `conv_busy` out 1: high while the BCD conversion FSM is not IDLE.

## Operation
- **Conversion FSM** has three states: IDLE, SHIFT, LATCH.
  - IDLE: on `tick_1khz`, sample `value` into a 14-bit shift register, clear the 16-bit BCD accumulator, load iteration count 13, set an overflow flag if `value` > 9999, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd,bin} left by 1. After the iteration with count 0, go to LATCH.
  - LATCH: copy the BCD result (or four dash codes if overflow) into the 4-digit display register, then return to IDLE.
  - A `tick_1khz` arriving outside IDLE is ignored by the FSM. The scan counter still uses it.
- **Scan:** a 2-bit index increments on every `tick_1khz` and wraps 3→0. The first tick after reset selects digit 0.
- **Digit code (active-high form):**
  - Digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Dash: 40. Blank: 00.
- **Leading-zero blanking:** digits 3..1 are blank when the digit is 0 and every higher digit is 0. Digit 0 is never blanked. No blanking applies in overflow.
- **Decimal point:** seg[7] = `dp_mask[idx]`, including on a blanked digit.
- **Blink:**
  - While `blink`=1, a counter counts ticks 0..`BLINK_TICKS`-1 and toggles `phase` on wrap. While `phase`=1, the whole segment byte, including dp, is forced to 00. `fnd_sel` keeps scanning.
  - While `blink`=0, the counter and `phase` are held at 0, so the display is lit immediately.
- **Polarity:** inversion is applied last, after the blank/blink decision.
- **Reset values:**
  - Outputs: `fnd_sel` = all digits inactive (1111 with default params), `fnd_seg` = all off (FF with default params), `conv_busy` = 0.
  - Internal: idx=0, display register = 0, `phase`=0, FSM = IDLE.
  - Outputs stay in the reset state until the first `tick_1khz`.
- **Reset mid-conversion:** asynchronous return to the reset state. No partial result reaches the display register.

## Timing
- `fnd_sel` and `fnd_seg` are registered. Both change together on the clock edge that samples `tick_1khz`, and are visible the following cycle. Sel and seg never disagree for a cycle.
- **Conversion latency:** tick sampled at edge n.
  - `conv_busy` is high from after edge n through the LATCH cycle: 14 SHIFT cycles + 1 LATCH cycle = 15 cycles.
  - The display register updates at edge n+15.
- The digit scanned at edge n uses the display register from before the conversion. A new value appears on each digit at that digit's next scan, at most 4 ticks later.
- `value` is only sampled at the tick edge in IDLE. Changes mid-conversion have no effect.
- `blink` is sampled every cycle. It takes effect on the segment output at the next tick edge.

## Test plan
Expected byte values assume default (active-low) parameters unless stated.

- **Value 1234, `dp_mask`=0, 4 ticks after the first conversion:** `fnd_sel` steps 1110, 1101, 1011, 0111. `fnd_seg` steps 99, B0, A4, F9.
- **Value 7:** digits 3..1 show FF and digit 0 shows F8. **Value 0:** digit 0 shows C0 and the others show FF. **`dp_mask`=0010, value 5:** digit 1 shows 7F.
- **Value 10000:** all four digits show BF. **Then value 9999:** all digits show 90.
- **Conversion timing:** on a single tick in IDLE, `conv_busy` is high for exactly 15 cycles. A second tick forced 5 cycles later does not restart the conversion; the result still equals the first sample.
- **Blink, `BLINK_TICKS`=4:** with `blink`=1, segments are on for ticks 0..3, FF for ticks 4..7, then on again. When `blink` drops during an off phase, segments are lit at the next tick.
- **Reset mid-conversion:** pulse `rst_n` low during SHIFT. `fnd_sel`=1111, `fnd_seg`=FF and `conv_busy`=0 asynchronously. After release, the first tick selects digit 0 showing C0.
